// File: rtl/axi4_lite_io_periph_pkg.sv
// -----------------------------------------------------------------------------
// axi4_lite_io_pkg
// Shared constants for the AXI4-Lite I/O peripheral:
//   - byte offsets of the register map
//   - read-only ID value
//   - AXI response codes
//   - active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
package axi4_lite_io_pkg;

    localparam logic [7:0] OFF_LED_CTRL   = 8'h00;
    localparam logic [7:0] OFF_SEG_DATA   = 8'h04;
    localparam logic [7:0] OFF_IRQ_STATUS = 8'h08;
    localparam logic [7:0] OFF_IRQ_ENABLE = 8'h0C;
    localparam logic [7:0] OFF_ID         = 8'h10;

    localparam logic [31:0] ID_VALUE = 32'hA411_0001;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Entry [n] is the pattern for hex digit n (a segment is lit when its bit is 0).
    localparam logic [15:0][6:0] SEG_LUT = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/axi4_lite_io_periph_if.sv
// -----------------------------------------------------------------------------
// axi4_lite_io_periph_if
// AXI4-Lite bus bundle for the I/O peripheral.
//   slave  modport : used by axi4_lite_io_periph
//   master modport : used by whatever drives the bus (interconnect / bench)
// Parameters: ADDR_WIDTH (address bits), DATA_WIDTH (data bits, 32).
// -----------------------------------------------------------------------------
interface axi4_lite_io_periph_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]              S_AXI_AWPROT;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]              S_AXI_ARPROT;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/axi4_lite_io_periph_hex_to_7seg.sv
// -----------------------------------------------------------------------------
// hex_to_7seg
// Combinational hex nibble to active-low 7-segment decoder.
//   i_nibble : 4-bit hex digit
//   o_seg    : segments {g,f,e,d,c,b,a}, 0 = lit
// -----------------------------------------------------------------------------
module hex_to_7seg
    import axi4_lite_io_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);
    assign o_seg = SEG_LUT[i_nibble];
endmodule

// File: rtl/axi4_lite_io_periph.sv
// -----------------------------------------------------------------------------
// axi4_lite_io_periph
// AXI4-Lite leaf slave with LED, 4-digit multiplexed 7-segment and IRQ logic.
// Ports:
//   ACLK, ARESET      : clock, synchronous active-high reset
//   s_axi (slave)     : AXI4-Lite bus bundle
//   EXT_IRQ_IN        : external interrupt source (rising edge latched)
//   LED[3:0]          : LED drive, active-high
//   SEG_CATHODE[6:0]  : segments {g,f,e,d,c,b,a}, active-low
//   SEG_ANODE[3:0]    : digit select, active-low one-hot
//   IRQ_OUT           : level interrupt = STATUS & ENABLE (registered)
// Build option: define IRQ_SYNC_EN to put a 2-flop synchronizer in front of
// the EXT_IRQ_IN edge detector.
// -----------------------------------------------------------------------------
module axi4_lite_io_periph
    import axi4_lite_io_pkg::*;
#(
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int REFRESH_DIV = 4
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    axi4_lite_io_periph_if.slave        s_axi,
    input  logic                        EXT_IRQ_IN,
    output logic [3:0]                  LED,
    output logic [6:0]                  SEG_CATHODE,
    output logic [3:0]                  SEG_ANODE,
    output logic                        IRQ_OUT
);
    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int CNT_W = DIV_W + 2;

    logic [3:0]            r_led;
    logic [15:0]           r_seg;
    logic                  r_irq_status;
    logic                  r_irq_enable;
    logic                  r_irq_out;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_irq_prev;
    logic [CNT_W-1:0]      r_refresh_cnt;

    logic [ADDR_WIDTH-1:0] w_aw_off;
    logic [ADDR_WIDTH-1:0] w_ar_off;
    logic                  w_wr_hs;
    logic                  w_rd_hs;
    logic                  w_wr_led;
    logic                  w_wr_seg;
    logic                  w_wr_stat;
    logic                  w_wr_en;
    logic                  w_irq_cur;
    logic                  w_irq_rise;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [1:0]            w_rd_resp;
    logic [1:0]            w_idx;
    logic [3:0]            w_digit [4];
    logic [3:0]            w_anode;
    logic [6:0]            w_seg_pat;
    logic                  w_unused;

    // Word access only: low address bits are dropped before decode.
    assign w_aw_off = {s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:2], 2'b00};
    assign w_ar_off = {s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:2], 2'b00};

    // Ready is combinational so the register updates on the accepting edge.
    // Gated by ARESET so nothing is accepted (or shown as accepted) in reset.
    assign w_wr_hs = s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !r_bvalid && !ARESET;
    assign w_rd_hs = s_axi.S_AXI_ARVALID && !r_rvalid && !ARESET;

    assign s_axi.S_AXI_AWREADY = w_wr_hs;
    assign s_axi.S_AXI_WREADY  = w_wr_hs;
    assign s_axi.S_AXI_ARREADY = w_rd_hs;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = r_bresp;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RRESP   = r_rresp;
    assign s_axi.S_AXI_RDATA   = r_rdata;

    assign w_wr_led  = w_wr_hs && (w_aw_off == ADDR_WIDTH'(OFF_LED_CTRL));
    assign w_wr_seg  = w_wr_hs && (w_aw_off == ADDR_WIDTH'(OFF_SEG_DATA));
    assign w_wr_stat = w_wr_hs && (w_aw_off == ADDR_WIDTH'(OFF_IRQ_STATUS));
    assign w_wr_en   = w_wr_hs && (w_aw_off == ADDR_WIDTH'(OFF_IRQ_ENABLE));

    // ---------------- write channel + register file ----------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_bvalid     <= 1'b0;
            r_bresp      <= RESP_OKAY;
            r_led        <= '0;
            r_seg        <= '0;
            r_irq_enable <= 1'b0;
        end else begin
            if (w_wr_hs) begin
                r_bvalid <= 1'b1;
                // ID and the unmapped hole answer SLVERR; no register is touched.
                r_bresp  <= (w_wr_led || w_wr_seg || w_wr_stat || w_wr_en) ? RESP_OKAY : RESP_SLVERR;
            end else if (r_bvalid && s_axi.S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
            if (w_wr_led && s_axi.S_AXI_WSTRB[0]) r_led        <= s_axi.S_AXI_WDATA[3:0];
            if (w_wr_seg && s_axi.S_AXI_WSTRB[0]) r_seg[7:0]   <= s_axi.S_AXI_WDATA[7:0];
            if (w_wr_seg && s_axi.S_AXI_WSTRB[1]) r_seg[15:8]  <= s_axi.S_AXI_WDATA[15:8];
            if (w_wr_en  && s_axi.S_AXI_WSTRB[0]) r_irq_enable <= s_axi.S_AXI_WDATA[0];
        end
    end

    // ---------------- interrupt path ----------------
`ifdef IRQ_SYNC_EN
    logic [1:0] r_irq_sync;
    always_ff @(posedge ACLK) begin
        if (ARESET) r_irq_sync <= '0;
        else        r_irq_sync <= {r_irq_sync[0], EXT_IRQ_IN};
    end
    assign w_irq_cur = r_irq_sync[1];
`else
    assign w_irq_cur = EXT_IRQ_IN;
`endif

    assign w_irq_rise = w_irq_cur && !r_irq_prev;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_irq_prev   <= 1'b0;
            r_irq_status <= 1'b0;
            r_irq_out    <= 1'b0;
        end else begin
            r_irq_prev <= w_irq_cur;
            // A new edge beats a simultaneous write-1-to-clear.
            if (w_irq_rise)                               r_irq_status <= 1'b1;
            else if (w_wr_stat && s_axi.S_AXI_WDATA[0])   r_irq_status <= 1'b0;
            r_irq_out <= r_irq_status && r_irq_enable;
        end
    end

    // ---------------- read channel ----------------
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        case (w_ar_off)
            ADDR_WIDTH'(OFF_LED_CTRL):   w_rd_data[3:0]  = r_led;
            ADDR_WIDTH'(OFF_SEG_DATA):   w_rd_data[15:0] = r_seg;
            ADDR_WIDTH'(OFF_IRQ_STATUS): w_rd_data[0]    = r_irq_status;
            ADDR_WIDTH'(OFF_IRQ_ENABLE): w_rd_data[0]    = r_irq_enable;
            ADDR_WIDTH'(OFF_ID):         w_rd_data       = DATA_WIDTH'(ID_VALUE);
            default:                     w_rd_resp       = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rvalid <= 1'b0;
            r_rresp  <= RESP_OKAY;
            r_rdata  <= '0;
        end else if (w_rd_hs) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_rd_resp;
            r_rdata  <= w_rd_data;
        end else if (r_rvalid && s_axi.S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    // ---------------- display multiplexing ----------------
    // Upper two counter bits are the digit index; the rest divide by REFRESH_DIV.
    always_ff @(posedge ACLK) begin
        if (ARESET) r_refresh_cnt <= '0;
        else        r_refresh_cnt <= r_refresh_cnt + 1'b1;
    end

    assign w_idx = r_refresh_cnt[CNT_W-1:DIV_W];

    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        assign w_digit[gi] = r_seg[4*gi +: 4];
        assign w_anode[gi] = (w_idx != 2'(gi));
    end

    hex_to_7seg u_hex_to_7seg (
        .i_nibble (w_digit[w_idx]),
        .o_seg    (w_seg_pat)
    );

    // Blank while reset is held; digit 0 is driven from the first cycle after.
    assign SEG_ANODE   = ARESET ? 4'hF    : w_anode;
    assign SEG_CATHODE = ARESET ? 7'h7F   : w_seg_pat;
    assign LED         = r_led;
    assign IRQ_OUT     = r_irq_out;

    assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0],
                        s_axi.S_AXI_WDATA[DATA_WIDTH-1:16], s_axi.S_AXI_WSTRB[DATA_WIDTH/8-1:2]};

endmodule

// File: tb/tb_axi4_lite_io_periph.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_io_periph
// Directed, table-driven bench for axi4_lite_io_periph.
// -----------------------------------------------------------------------------
module tb_axi4_lite_io_periph;

`ifdef IRQ_SYNC_EN
    localparam int IRQ_LAT = 3;
`else
    localparam int IRQ_LAT = 1;
`endif

    logic       ACLK = 1'b0;
    logic       ARESET = 1'b1;
    logic       EXT_IRQ_IN = 1'b0;
    logic [3:0] LED;
    logic [6:0] SEG_CATHODE;
    logic [3:0] SEG_ANODE;
    logic       IRQ_OUT;

    int n_checks = 0;
    int n_pass   = 0;

    axi4_lite_io_periph_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) axi ();

    axi4_lite_io_periph #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .REFRESH_DIV(4)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .s_axi       (axi.slave),
        .EXT_IRQ_IN  (EXT_IRQ_IN),
        .LED         (LED),
        .SEG_CATHODE (SEG_CATHODE),
        .SEG_ANODE   (SEG_ANODE),
        .IRQ_OUT     (IRQ_OUT)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  bresp;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic [3:0]  led;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else             n_pass++;
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        @(posedge ACLK); #1;
        axi.S_AXI_AWADDR  = a;
        axi.S_AXI_WDATA   = d;
        axi.S_AXI_WSTRB   = s;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WVALID  = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!axi.S_AXI_AWREADY && n < 20) begin @(negedge ACLK); n++; end
        check("wr_awready", {31'd0, axi.S_AXI_AWREADY}, 32'd1);
        @(posedge ACLK); #1;
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        @(negedge ACLK);
        check("wr_bvalid_next", {31'd0, axi.S_AXI_BVALID}, 32'd1);
        resp = axi.S_AXI_BRESP;
        axi.S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        axi.S_AXI_BREADY = 1'b0;
        $display("wr addr=%h data=%h strb=%h bresp=%b", a, d, s, resp);
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        @(posedge ACLK); #1;
        axi.S_AXI_ARADDR  = a;
        axi.S_AXI_ARVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!axi.S_AXI_ARREADY && n < 20) begin @(negedge ACLK); n++; end
        check("rd_arready", {31'd0, axi.S_AXI_ARREADY}, 32'd1);
        @(posedge ACLK); #1;
        axi.S_AXI_ARVALID = 1'b0;
        @(negedge ACLK);
        check("rd_rvalid_next", {31'd0, axi.S_AXI_RVALID}, 32'd1);
        d    = axi.S_AXI_RDATA;
        resp = axi.S_AXI_RRESP;
        axi.S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        axi.S_AXI_RREADY = 1'b0;
        $display("rd addr=%h data=%h rresp=%b", a, d, resp);
    endtask

    // Expected segment patterns {g..a}, active-low, for the digits used here.
    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            default: return 7'b1111111;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [3:0]  exp_an;
        logic [6:0]  exp_cat;
        int n;

        vecs[0]  = '{5'h00, 32'h0000_0005, 4'hF, 2'b00, 32'h0000_0005, 2'b00, 4'h5};
        vecs[1]  = '{5'h00, 32'hFFFF_FFFA, 4'hE, 2'b00, 32'h0000_0005, 2'b00, 4'h5};
        vecs[2]  = '{5'h04, 32'h0000_ABCD, 4'hF, 2'b00, 32'h0000_ABCD, 2'b00, 4'h5};
        vecs[3]  = '{5'h04, 32'h0000_1200, 4'h2, 2'b00, 32'h0000_12CD, 2'b00, 4'h5};
        vecs[4]  = '{5'h04, 32'h0000_0034, 4'h1, 2'b00, 32'h0000_1234, 2'b00, 4'h5};
        vecs[5]  = '{5'h0C, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0000_0001, 2'b00, 4'h5};
        vecs[6]  = '{5'h0C, 32'h0000_0000, 4'hF, 2'b00, 32'h0000_0000, 2'b00, 4'h5};
        vecs[7]  = '{5'h08, 32'h0000_0001, 4'hF, 2'b00, 32'h0000_0000, 2'b00, 4'h5};
        vecs[8]  = '{5'h10, 32'h1234_5678, 4'hF, 2'b10, 32'hA411_0001, 2'b00, 4'h5};
        vecs[9]  = '{5'h14, 32'h0000_0001, 4'hF, 2'b10, 32'h0000_0000, 2'b10, 4'h5};
        vecs[10] = '{5'h18, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0000_0000, 2'b10, 4'h5};
        vecs[11] = '{5'h1C, 32'h0000_0001, 4'hF, 2'b10, 32'h0000_0000, 2'b10, 4'h5};

        axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WDATA  = '0; axi.S_AXI_WSTRB  = '0; axi.S_AXI_WVALID  = 1'b0;
        axi.S_AXI_BREADY = 1'b0;
        axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0; axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_RREADY = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_led",     {28'd0, LED}, 32'h0);
        check("rst_anode",   {28'd0, SEG_ANODE}, 32'hF);
        check("rst_cathode", {25'd0, SEG_CATHODE}, 32'h7F);
        check("rst_flags",   {28'd0, IRQ_OUT, axi.S_AXI_BVALID, axi.S_AXI_RVALID, axi.S_AXI_AWREADY}, 32'h0);
        check("rst_rdata",   axi.S_AXI_RDATA, 32'h0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        check("post_rst_digit0", {21'd0, SEG_ANODE, SEG_CATHODE}, {21'd0, 4'b1110, 7'b1000000});

        // ---- register map vectors ----
        for (int i = 0; i < 12; i++) begin
            axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, resp);
            check($sformatf("v%0d_bresp", i), {30'd0, resp}, {30'd0, vecs[i].bresp});
            axi_read(vecs[i].addr, rd, resp);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("v%0d_rresp", i), {30'd0, resp}, {30'd0, vecs[i].rresp});
            @(negedge ACLK);
            check($sformatf("v%0d_led", i), {28'd0, LED}, {28'd0, vecs[i].led});
        end

        // ---- display scan with SEG_DATA = 0x1234 ----
        n = 0;
        @(negedge ACLK);
        while (SEG_ANODE != 4'b0111 && n < 40) begin @(negedge ACLK); n++; end
        while (SEG_ANODE != 4'b1110 && n < 40) begin @(negedge ACLK); n++; end
        check("disp_sync", {31'd0, n < 40}, 32'd1);
        for (int k = 0; k < 16; k++) begin
            exp_an  = ~(4'b0001 << (k / 4));
            exp_cat = seg_of(4'(4 - k / 4));
            check($sformatf("disp_k%0d", k), {21'd0, SEG_ANODE, SEG_CATHODE}, {21'd0, exp_an, exp_cat});
            @(negedge ACLK);
        end

        // ---- interrupt: enable, pulse, latency ----
        axi_write(5'h0C, 32'h1, 4'hF, resp);
        @(posedge ACLK); #1;
        EXT_IRQ_IN = 1'b1;
        for (int k = 1; k <= IRQ_LAT + 2; k++) begin
            @(posedge ACLK);
            @(negedge ACLK);
            if (k == 1) EXT_IRQ_IN = 1'b0;
            check($sformatf("irq_lat_k%0d", k), {31'd0, IRQ_OUT}, {31'd0, k >= IRQ_LAT + 1});
        end
        axi_read(5'h08, rd, resp);
        check("irq_status_set", rd, 32'h1);
        axi_write(5'h08, 32'h0, 4'hF, resp);
        axi_read(5'h08, rd, resp);
        check("irq_w0_noclear", rd, 32'h1);
        axi_write(5'h08, 32'h1, 4'hF, resp);
        axi_read(5'h08, rd, resp);
        check("irq_w1c", rd, 32'h0);
        @(negedge ACLK);
        check("irq_out_cleared", {31'd0, IRQ_OUT}, 32'h0);

        // status latches while disabled; enabling later raises IRQ_OUT
        axi_write(5'h0C, 32'h0, 4'hF, resp);
        @(posedge ACLK); #1; EXT_IRQ_IN = 1'b1;
        @(posedge ACLK); #1; EXT_IRQ_IN = 1'b0;
        repeat (6) @(posedge ACLK);
        @(negedge ACLK);
        check("irq_masked", {31'd0, IRQ_OUT}, 32'h0);
        axi_read(5'h08, rd, resp);
        check("irq_masked_status", rd, 32'h1);
        axi_write(5'h0C, 32'h1, 4'hF, resp);
        @(negedge ACLK);
        check("irq_unmasked", {31'd0, IRQ_OUT}, 32'h1);

        // ---- write response backpressure ----
        @(posedge ACLK); #1;
        axi.S_AXI_AWADDR = 5'h00; axi.S_AXI_WDATA = 32'h3; axi.S_AXI_WSTRB = 4'hF;
        axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        check("bp_wr_accept", {31'd0, axi.S_AXI_AWREADY}, 32'h1);
        @(posedge ACLK); #1;
        axi.S_AXI_WDATA = 32'hA;
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            check($sformatf("bp_wr_hold%0d", k),
                  {24'd0, axi.S_AXI_BVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_BRESP, 3'd0, LED[0]} ,
                  {24'd0, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0, 1'b1});
            check($sformatf("bp_wr_led%0d", k), {28'd0, LED}, 32'h3);
        end
        @(posedge ACLK); #1; axi.S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1; axi.S_AXI_BREADY = 1'b0;
        @(negedge ACLK);
        check("bp_wr_release", {30'd0, axi.S_AXI_BVALID, axi.S_AXI_AWREADY}, 32'b01);
        @(posedge ACLK); #1;
        axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
        @(negedge ACLK);
        check("bp_wr_second", {27'd0, axi.S_AXI_BVALID, LED}, {27'd0, 1'b1, 4'hA});
        axi.S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1; axi.S_AXI_BREADY = 1'b0;

        // ---- read data backpressure ----
        @(posedge ACLK); #1;
        axi.S_AXI_ARADDR = 5'h10; axi.S_AXI_ARVALID = 1'b1;
        @(negedge ACLK);
        check("bp_rd_accept", {31'd0, axi.S_AXI_ARREADY}, 32'h1);
        @(posedge ACLK); #1;
        axi.S_AXI_ARADDR = 5'h00;
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            check($sformatf("bp_rd_hold%0d", k),
                  {28'd0, axi.S_AXI_RVALID, axi.S_AXI_ARREADY, axi.S_AXI_RRESP}, {28'd0, 1'b1, 1'b0, 2'b00});
            check($sformatf("bp_rd_data%0d", k), axi.S_AXI_RDATA, 32'hA411_0001);
        end
        @(posedge ACLK); #1; axi.S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1; axi.S_AXI_RREADY = 1'b0;
        @(negedge ACLK);
        check("bp_rd_release", {30'd0, axi.S_AXI_RVALID, axi.S_AXI_ARREADY}, 32'b01);
        @(posedge ACLK); #1;
        axi.S_AXI_ARVALID = 1'b0;
        @(negedge ACLK);
        check("bp_rd_second", {31'd0, axi.S_AXI_RVALID}, 32'h1);
        check("bp_rd_second_data", axi.S_AXI_RDATA, 32'hA);
        axi.S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1; axi.S_AXI_RREADY = 1'b0;

        // ---- reset in the middle of a write ----
        @(posedge ACLK); #1;
        axi.S_AXI_AWADDR = 5'h00; axi.S_AXI_WDATA = 32'hF; axi.S_AXI_WSTRB = 4'hF;
        axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
        @(posedge ACLK); #1;
        axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
        @(negedge ACLK);
        check("mid_pre", {26'd0, IRQ_OUT, axi.S_AXI_BVALID, LED}, {26'd0, 1'b1, 1'b1, 4'hF});
        @(posedge ACLK); #1;
        ARESET = 1'b1;
        axi.S_AXI_ARADDR = 5'h10; axi.S_AXI_ARVALID = 1'b1;
        @(negedge ACLK);
        check("mid_rst_gate", {27'd0, axi.S_AXI_ARREADY, SEG_ANODE}, {27'd0, 1'b0, 4'hF});
        @(posedge ACLK);
        @(negedge ACLK);
        check("mid_rst_led", {28'd0, LED}, 32'h0);
        check("mid_rst_flags", {28'd0, IRQ_OUT, axi.S_AXI_BVALID, axi.S_AXI_RVALID, axi.S_AXI_AWREADY}, 32'h0);
        check("mid_rst_resp", {28'd0, axi.S_AXI_BRESP, axi.S_AXI_RRESP}, 32'h0);
        check("mid_rst_rdata", axi.S_AXI_RDATA, 32'h0);
        check("mid_rst_cathode", {25'd0, SEG_CATHODE}, 32'h7F);
        @(posedge ACLK); #1;
        axi.S_AXI_ARVALID = 1'b0;
        ARESET = 1'b0;
        @(negedge ACLK);
        check("mid_post_digit0", {21'd0, SEG_ANODE, SEG_CATHODE}, {21'd0, 4'b1110, 7'b1000000});
        axi_read(5'h0C, rd, resp);
        check("mid_post_enable", rd, 32'h0);
        axi_read(5'h04, rd, resp);
        check("mid_post_seg", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi4_lite_io_periph.md
Name: axi4_lite_io_periph

Overview:
- AXI4-Lite slave peripheral with a small register file driving four LEDs, a 4-digit multiplexed 7-segment display and a level interrupt output.
- Latches rising edges on an external interrupt input.
- Sits on the system AXI4-Lite interconnect as a leaf slave; all I/O pins connect to board-level outputs.

Parameters:
- ADDR_WIDTH, 5, AXI address width; bits [1:0] ignored (word access).
- DATA_WIDTH, 32, AXI data width; fixed at 32.
- REFRESH_DIV, 4, ACLK cycles per displayed digit (power of two, ≥2).

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous active-high reset.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID  out  1  read valid.
- S_AXI_RREADY  in  1  read ready.
- EXT_IRQ_IN  in  1  external interrupt source.
- LED  out  4  LED drive (active-high).
- SEG_CATHODE  out  7  segments {g,f,e,d,c,b,a}, active-low.
- SEG_ANODE  out  4  digit select, active-low one-hot.
- IRQ_OUT  out  1  interrupt request (level).

Behaviour:
- Register map (word offsets):
  - 0x00 LED_CTRL RW [3:0], drives LED directly.
  - 0x04 SEG_DATA RW [15:0], digit i = nibble [4i+3:4i].
  - 0x08 IRQ_STATUS [0]; set by EXT_IRQ_IN rising edge; write-1-to-clear.
  - 0x0C IRQ_ENABLE RW [0].
  - 0x10 ID RO = 0xA4110001.
- Unused register bits read 0. WSTRB byte enables are honoured on RW registers.
- Write channel:
  - AWREADY and WREADY pulse high together for one cycle when AWVALID && WVALID && !BVALID.
  - The register updates on that same edge.
  - BVALID rises the following cycle and holds with BRESP until BREADY; it clears on the BVALID && BREADY edge.
  - No write is accepted while BVALID=1.
- Read channel:
  - ARREADY pulses one cycle when ARVALID && !RVALID.
  - RVALID and RDATA are registered the next cycle and held stable until RREADY; RVALID clears on the handshake.
  - Read and write channels are fully independent.
- Responses:
  - OKAY (00) for mapped offsets.
  - SLVERR (10) for offsets 0x14–0x1C and for writes to ID. Such writes have no effect; such reads return 0.
- IRQ:
  - EXT_IRQ_IN is registered once. A rise is detected when current=1 and previous=0, and sets STATUS on the following edge.
  - If a set and a W1C occur on the same edge, set wins.
  - IRQ_OUT = STATUS & ENABLE, registered (one cycle after either changes).
- Display:
  - Free-running counter; digit index advances 0→1→2→3→0 every REFRESH_DIV cycles.
  - SEG_ANODE = ~(1<<idx). SEG_CATHODE = hex decode of the selected nibble; 0–F use standard patterns, e.g. 0 → 7'b1000000, 8 → 7'b0000000.
- Reset (ARESET=1 at posedge):
  - All registers cleared, counter and index = 0.
  - LED=0, SEG_ANODE=4'b1111, SEG_CATHODE=7'b1111111, IRQ_OUT=0.
  - All READY/VALID outputs = 0, BRESP/RRESP = 0, RDATA = 0.
  - In-flight transactions are dropped.
  - From the first cycle after reset, the display is driven normally: digit 0 shows "0".

Optional Feature:
- Macro IRQ_SYNC_EN.
  - Defined: EXT_IRQ_IN passes through a 2-flop synchronizer before the edge-detect flop. STATUS sets 3 cycles after the input rises.
  - Undefined: single edge-detect flop; STATUS sets 1 cycle after the rise.

Decomposition:
- Package axi4_lite_io_pkg holds:
  - register offset localparams;
  - ID value;
  - RESP_OKAY / RESP_SLVERR;
  - a 16-entry 7-segment pattern constant.
- One sub-module: hex_to_7seg (4-bit nibble in, 7-bit active-low segments out, combinational).

Test Plan:
- Write 0x00 data 0x5 WSTRB 4'hF -> BVALID next cycle, BRESP=00; LED=4'b0101; read 0x00 returns 0x00000005, RRESP=00.
- Write 0x04 data 0x1234 -> SEG_ANODE cycles 1110/1101/1011/0111 every 4 cycles; SEG_CATHODE shows 4,3,2,1 patterns.
- Write ENABLE=1, pulse EXT_IRQ_IN -> STATUS reads 1, IRQ_OUT=1. Write 0x08 data 1 -> STATUS=0, IRQ_OUT=0.
- Read 0x10 -> 0xA4110001, OKAY. Write 0x10 -> SLVERR, value unchanged. Read 0x18 -> RDATA=0, RRESP=10.
- Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID and data stay stable; no new AWREADY/ARREADY until the handshake completes.
- Assert ARESET mid-write with LED=0xF -> all outputs return to reset values; LED=0.
